// File: rtl/lutram_reader_pkg.sv
// Shared types for the LUTRAM stream reader: FSM state encoding and the burst request record.
// Request fields are sized for address widths up to REQ_AW_MAX; narrower instances zero-extend.
package lutram_reader_pkg;

   localparam int unsigned REQ_AW_MAX = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } reader_state_e;

   typedef struct packed {
      logic [REQ_AW_MAX-1:0] base;
      logic [REQ_AW_MAX:0]   len;
   } reader_req_t;

endpackage

// File: rtl/lutram_stream_reader_skid_buf.sv
// Two-entry output buffer (module reader_skid_buf) catching RAM read data one cycle after enb.
// The reader never pushes when full without a same-cycle pop and never pops when empty.
module reader_skid_buf
   import lutram_reader_pkg::*;
#(
   parameter int DATA_WIDTH = 128
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   input  logic                  push_last_i,
   input  logic                  pop_i,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  last_o
);

   logic [DATA_WIDTH-1:0] data_q [2];
   logic [1:0]            last_q;
   logic                  wr_q;
   logic                  rd_q;
   logic [1:0]            count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q[0] <= '0;
         data_q[1] <= '0;
         last_q    <= '0;
         wr_q      <= 1'b0;
         rd_q      <= 1'b0;
         count_q   <= 2'd0;
      end else begin
         if (push_i) begin
            data_q[wr_q] <= push_data_i;
            last_q[wr_q] <= push_last_i;
            wr_q         <= ~wr_q;
         end
         if (pop_i) begin
            rd_q <= ~rd_q;
         end
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign full_o  = (count_q == 2'd2);
   assign empty_o = (count_q == 2'd0);
   assign data_o  = data_q[rd_q];
   // A stale last flag in a drained slot must never be visible.
   assign last_o  = last_q[rd_q] & ~empty_o;

endmodule

// File: rtl/lutram_stream_reader.sv
// Streams req_len words starting at req_base out of a 1-cycle-latency LUTRAM read port.
// Optional stall_cnt performance counter is enabled by defining LUTRAM_READER_PERF_EN.
module lutram_stream_reader
   import lutram_reader_pkg::*;
#(
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_base,
   input  logic [ADDR_WIDTH:0]   req_len,
   output logic                  enb,
   output logic [ADDR_WIDTH-1:0] addrb,
   input  logic [DATA_WIDTH-1:0] doutb,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  busy
`ifdef LUTRAM_READER_PERF_EN
   ,
   output logic [31:0]           stall_cnt
`endif
);

   localparam logic [REQ_AW_MAX-1:0] ADDR_MASK = {REQ_AW_MAX{1'b1}} >> (REQ_AW_MAX - ADDR_WIDTH);
   localparam logic [REQ_AW_MAX-1:0] BASE_ONE  = REQ_AW_MAX'(1);
   localparam logic [REQ_AW_MAX:0]   LEN_ONE   = (REQ_AW_MAX+1)'(1);

   reader_state_e state_q, state_d;
   // base tracks the next address to read, len the reads still to be issued.
   reader_req_t   req_q, req_d;
   logic          inflight_q;
   logic          inflight_last_q;
   logic          buf_full;
   logic          buf_empty;
   logic          buf_last;
   logic          pop;
   logic          issue;
   logic          last_issue;
   logic [1:0]    occupancy;

   assign out_valid = ~buf_empty;
   assign out_last  = buf_last;
   assign pop       = out_valid & out_ready;
   assign occupancy = buf_full ? 2'd2 : (buf_empty ? 2'd0 : 2'd1);

   // Reserve a buffer slot for every read before issuing it so no returning word is lost.
   assign issue      = (state_q == ST_RUN) &&
                       (({1'b0, occupancy} + {2'b00, inflight_q} - {2'b00, pop}) < 3'd2);
   assign last_issue = issue && (req_q.len == LEN_ONE);

   assign enb       = issue;
   assign addrb     = issue ? req_q.base[ADDR_WIDTH-1:0] : '0;
   assign req_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid && (req_len != '0)) begin
               req_d.base = REQ_AW_MAX'(req_base);
               req_d.len  = (REQ_AW_MAX+1)'(req_len);
               state_d    = ST_RUN;
            end
         end
         ST_RUN: begin
            if (issue) begin
               req_d.base = (req_q.base + BASE_ONE) & ADDR_MASK;
               req_d.len  = req_q.len - LEN_ONE;
               if (last_issue) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (pop && buf_last) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= ST_IDLE;
         req_q           <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         req_q           <= req_d;
         inflight_q      <= issue;
         inflight_last_q <= last_issue;
      end
   end

   reader_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid_buf (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (inflight_q),
      .push_data_i (doutb),
      .push_last_i (inflight_last_q),
      .pop_i       (pop),
      .full_o      (buf_full),
      .empty_o     (buf_empty),
      .data_o      (out_data),
      .last_o      (buf_last)
   );

`ifdef LUTRAM_READER_PERF_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else if (out_valid && !out_ready && (stall_q != '1)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_lutram_stream_reader.sv
// Scoreboard bench for lutram_stream_reader with a behavioural 1-cycle LUTRAM model.
// Define LUTRAM_READER_PERF_EN to also exercise the stall counter.
module tb_lutram_stream_reader;

   localparam int DW = 128;
   localparam int AW = 8;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic [AW-1:0] req_base;
   logic [AW:0]   req_len;
   logic          enb;
   logic [AW-1:0] addrb;
   logic [DW-1:0] doutb = '0;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          busy;
`ifdef LUTRAM_READER_PERF_EN
   logic [31:0]   stall_cnt;
`endif

   lutram_stream_reader #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_base  (req_base),
      .req_len   (req_len),
      .enb       (enb),
      .addrb     (addrb),
      .doutb     (doutb),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy)
`ifdef LUTRAM_READER_PERF_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int    checks = 0;
   int    passes = 0;
   int    cycle = 0;
   int    enbCount = 0;
   int    beatCount = 0;
   int    validSeen = 0;
   int    acceptCycle = 0;
   beat_t expBeat[$];
   logic [AW-1:0] expAddr[$];
   logic [AW-1:0] addrLog[$];
   int    enbCycle[$];
   int    beatCycle[$];
   int    validCycle[$];
   logic          prevStall = 1'b0;
   logic [DW-1:0] prevData = '0;
   logic          prevLast = 1'b0;

   // RAM contents: each word encodes its own address so misordered reads are obvious.
   function automatic logic [DW-1:0] ramWord(input logic [AW-1:0] a);
      return {4{(24'hA5C300 | {16'h0000, a}), (a ^ 8'h5A)}};
   endfunction

   always @(posedge clk) begin
      cycle <= cycle + 1;
      if (enb) doutb <= ramWord(addrb);
   end

   task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                              input logic [DW-1:0] expected);
      checks++;
      if (actual === expected) passes++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
   endtask

   task automatic reportFail(input string name);
      checks++;
      $display("[TB] FAIL %s: got an unexpected event or timeout, expected none", name);
   endtask

   // Monitor: pops the scoreboard on every read issue and every beat handshake.
   always @(negedge clk) begin
      beat_t b;
      if (rst_n === 1'b1) begin
         if (prevStall) begin
            checkOutput("hold_valid", DW'(out_valid), DW'(1'b1));
            checkOutput("hold_data", out_data, prevData);
            checkOutput("hold_last", DW'(out_last), DW'(prevLast));
         end
         if (enb) begin
            enbCount++;
            addrLog.push_back(addrb);
            enbCycle.push_back(cycle);
            if (expAddr.size() == 0) reportFail("addrb_unexpected");
            else checkOutput("addrb", DW'(addrb), DW'(expAddr.pop_front()));
         end
         if (out_valid) begin
            validSeen++;
            validCycle.push_back(cycle);
         end
         if (out_valid && out_ready) begin
            beatCount++;
            beatCycle.push_back(cycle);
            if (expBeat.size() == 0) reportFail("beat_unexpected");
            else begin
               b = expBeat.pop_front();
               checkOutput("out_data", out_data, b.data);
               checkOutput("out_last", DW'(out_last), DW'(b.last));
            end
         end
         prevStall = out_valid && !out_ready;
         prevData  = out_data;
         prevLast  = out_last;
      end else begin
         prevStall = 1'b0;
      end
   end

   task automatic clearLogs();
      addrLog.delete();
      enbCycle.delete();
      beatCycle.delete();
      validCycle.delete();
      enbCount  = 0;
      validSeen = 0;
   endtask

   // Called at posedge+1; presents one request and returns just after the accepting edge.
   task automatic applyStimulus(input logic [AW-1:0] base, input logic [AW:0] len);
      int guard;
      for (int n = 0; n < int'(len); n++) begin
         logic [AW-1:0] a;
         a = base + AW'(n);
         expAddr.push_back(a);
         expBeat.push_back('{data: ramWord(a), last: (n == int'(len) - 1)});
      end
      guard = 0;
      while (req_ready !== 1'b1 && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 50) reportFail("req_ready_timeout");
      req_valid = 1'b1;
      req_base  = base;
      req_len   = len;
      @(posedge clk); #1;
      acceptCycle = cycle;
      req_valid = 1'b0;
   endtask

   task automatic waitIdle(input int budget);
      int guard;
      guard = 0;
      while (!(expBeat.size() == 0 && req_ready === 1'b1) && guard < budget) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= budget) reportFail("drain_timeout");
   endtask

   task automatic waitOutValid(input int budget);
      int guard;
      guard = 0;
      while (out_valid !== 1'b1 && guard < budget) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= budget) reportFail("out_valid_timeout");
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_enb"}, DW'(enb), DW'(1'b0));
      checkOutput({tag, "_addrb"}, DW'(addrb), DW'(0));
      checkOutput({tag, "_out_valid"}, DW'(out_valid), DW'(1'b0));
      checkOutput({tag, "_out_last"}, DW'(out_last), DW'(1'b0));
      checkOutput({tag, "_out_data"}, out_data, DW'(0));
      checkOutput({tag, "_busy"}, DW'(busy), DW'(1'b0));
      checkOutput({tag, "_req_ready"}, DW'(req_ready), DW'(1'b1));
`ifdef LUTRAM_READER_PERF_EN
      checkOutput({tag, "_stall_cnt"}, DW'(stall_cnt), DW'(0));
`endif
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: got no completion, expected $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [AW-1:0] wantA[4];
      logic [AW-1:0] wantW[4];
      int beatBase;
      int guard;
`ifdef LUTRAM_READER_PERF_EN
      logic [31:0] stallBefore;
`endif

      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_base  = '0;
      req_len   = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkResetState("init");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Straight 4-word burst at 0x10 with the consumer always ready.
      clearLogs();
      out_ready = 1'b1;
      applyStimulus(8'h10, 9'd4);
      checkOutput("busy_after_accept", DW'(busy), DW'(1'b1));
      checkOutput("req_ready_after_accept", DW'(req_ready), DW'(1'b0));
      waitIdle(100);
      wantA = '{8'h10, 8'h11, 8'h12, 8'h13};
      checkOutput("burst4_enb_count", DW'(addrLog.size()), DW'(4));
      for (int i = 0; i < 4 && i < addrLog.size(); i++)
         checkOutput("burst4_addr", DW'(addrLog[i]), DW'(wantA[i]));
      if (enbCycle.size() == 4) checkOutput("burst4_enb_span", DW'(enbCycle[3] - enbCycle[0]), DW'(3));
      else reportFail("burst4_enb_missing");
      if (beatCycle.size() == 4) checkOutput("burst4_beat_span", DW'(beatCycle[3] - beatCycle[0]), DW'(3));
      else reportFail("burst4_beat_missing");
      if (validCycle.size() > 0) checkOutput("first_valid_latency", DW'(validCycle[0] - acceptCycle), DW'(2));
      else reportFail("first_valid_missing");
      checkOutput("burst4_busy_end", DW'(busy), DW'(1'b0));

      // Burst wrapping past the top address.
      clearLogs();
      applyStimulus(8'hFE, 9'd4);
      waitIdle(100);
      wantW = '{8'hFE, 8'hFF, 8'h00, 8'h01};
      checkOutput("wrap_enb_count", DW'(addrLog.size()), DW'(4));
      for (int i = 0; i < 4 && i < addrLog.size(); i++)
         checkOutput("wrap_addr", DW'(addrLog[i]), DW'(wantW[i]));

      // Consumer stalls for 5 cycles after the first beat: at most 2 words outstanding.
      clearLogs();
      beatBase = beatCount;
      applyStimulus(8'h20, 9'd8);
      waitOutValid(20);
      @(posedge clk); #1;
      out_ready = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
      end
      checkOutput("stall_enb_count", DW'(enbCount), DW'(3));
      checkOutput("stall_beats_so_far", DW'(beatCount - beatBase), DW'(1));
      out_ready = 1'b1;
      waitIdle(100);
      checkOutput("stall_beats_total", DW'(beatCount - beatBase), DW'(8));

      // Zero-length request is a no-op.
      clearLogs();
      applyStimulus(8'h33, 9'd0);
      repeat (6) begin
         checkOutput("len0_req_ready", DW'(req_ready), DW'(1'b1));
         @(posedge clk); #1;
      end
      checkOutput("len0_enb_count", DW'(enbCount), DW'(0));
      checkOutput("len0_valid_count", DW'(validSeen), DW'(0));

`ifdef LUTRAM_READER_PERF_EN
      // Exactly 3 stalled cycles on the first beat of a short burst.
      stallBefore = stall_cnt;
      out_ready = 1'b0;
      applyStimulus(8'h30, 9'd2);
      waitOutValid(20);
      repeat (3) begin
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      waitIdle(100);
      checkOutput("stall_cnt_delta", DW'(stall_cnt - stallBefore), DW'(3));
`endif

      // Reset in the middle of a 6-beat burst, then a fresh 2-beat burst.
      out_ready = 1'b1;
      beatBase = beatCount;
      applyStimulus(8'h60, 9'd6);
      guard = 0;
      while ((beatCount - beatBase) < 2 && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 50) reportFail("midburst_timeout");
      rst_n = 1'b0;
      expBeat.delete();
      expAddr.delete();
      @(negedge clk);
      #1;
      checkResetState("midreset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      beatBase = beatCount;
      applyStimulus(8'h40, 9'd2);
      waitIdle(100);
      repeat (6) begin
         @(posedge clk); #1;
      end
      checkOutput("after_reset_beats", DW'(beatCount - beatBase), DW'(2));
      checkOutput("after_reset_idle", DW'(req_ready), DW'(1'b1));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/lutram_stream_reader.md
LUTRAM_STREAM_READER -- requirements
Module: lutram_stream_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128: width of each RAM word and output beat.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8: RAM address width; RAM depth is 2**ADDR_WIDTH.
REQ-003 SHALL use one clock; reset is asynchronous and active-low; port clk  in  1  rising-edge clock.
REQ-004 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port req_valid  in  1  burst request present.
REQ-006 SHALL have port req_ready  out  1  reader idle, request accepted when both valid and ready are high.
REQ-007 SHALL have port req_base  in  ADDR_WIDTH  first word address.
REQ-008 SHALL have port req_len  in  ADDR_WIDTH+1  beat count, 0..2**ADDR_WIDTH.
REQ-009 SHALL have port enb  out  1  RAM read-port enable.
REQ-010 SHALL have port addrb  out  ADDR_WIDTH  RAM read address.
REQ-011 SHALL have port doutb  in  DATA_WIDTH  RAM read data, valid the cycle after enb.
REQ-012 SHALL have port out_valid  out  1  out_data holds a beat.
REQ-013 SHALL have port out_ready  in  1  consumer accepts the beat.
REQ-014 SHALL have port out_data  out  DATA_WIDTH  beat payload.
REQ-015 SHALL have port out_last  out  1  final beat of the burst.
REQ-016 SHALL have port busy  out  1  burst in progress.

Function
REQ-017 SHALL implement FSM IDLE -> RUN on accepted request with req_len>0; RUN -> DRAIN after the last enb; DRAIN -> IDLE on handshake of the out_last beat.
REQ-018 SHALL hold req_ready=1 only in IDLE; busy=1 in RUN and DRAIN.
REQ-019 SHALL accept req_len=0 as a no-op: no enb, no beat, FSM remains IDLE.
REQ-020 SHALL issue addrb = req_base + n (n = 0..req_len-1) modulo 2**ADDR_WIDTH, wrapping past the top address.
REQ-021 SHALL capture doutb into a 2-entry output buffer exactly one cycle after each enb cycle.
REQ-022 SHALL assert enb only when (buffered beats + in-flight reads - beat popped this cycle) < 2, so no read is ever lost.
REQ-023 SHALL first assert out_valid 2 cycles after the accepting edge (enb in cycle 1, doutb in cycle 2, buffer entry at cycle 3 edge -> out_valid from edge 2 of the request + 1 register stage).
REQ-024 SHALL sustain one beat per cycle while out_ready is held high.
REQ-025 SHALL hold out_data/out_valid/out_last stable while out_valid=1 and out_ready=0.
REQ-026 SHALL assert out_last only on beat req_len-1.
REQ-027 SHALL pass doutb unmodified; same-cycle write-forwarding by the RAM is transparent.
REQ-028 SHALL drive addrb=0 while enb=0.

Reset
REQ-029 SHALL on rst_n=0 force FSM=IDLE, buffer empty, in-flight count 0, enb=0, addrb=0, out_valid=0, out_last=0, out_data=0, busy=0, req_ready=1.
REQ-030 SHALL abandon any burst on reset mid-operation; no beats of it appear after release.

Configuration
REQ-031 SHALL, with LUTRAM_READER_PERF_EN defined, add output stall_cnt (32 bits), counting cycles with out_valid=1 and out_ready=0, reset to 0, saturating at all-ones.
REQ-032 SHALL, without LUTRAM_READER_PERF_EN, have no stall_cnt port and no counter logic.

Structure
REQ-033 SHALL place the FSM state enum and the request struct (base, len) in the shared package lutram_reader_pkg.
REQ-034 SHALL implement the 2-entry output buffer as sub-module reader_skid_buf (push, pop, full, empty, data, last).

Verification
REQ-035 SHALL cover: base=0x10, len=4, out_ready=1 -> addrb 0x10..0x13 on 4 consecutive cycles, 4 back-to-back beats with the contents of words 0x10..0x13, out_last on the 4th.
REQ-036 SHALL cover: base=0xFE, len=4 -> addrb sequence 0xFE, 0xFF, 0x00, 0x01.
REQ-037 SHALL cover: len=8, out_ready low for 5 cycles after the first beat -> enb stops after 2 outstanding beats, no beat is dropped or duplicated, all 8 beats delivered in order.
REQ-038 SHALL cover: len=0 -> no enb and no out_valid; req_ready stays 1.
REQ-039 SHALL cover: rst_n low mid-burst (after beat 2 of 6), then base=0x40, len=2 -> outputs cleared during reset, only the 2 new beats are delivered afterwards.
REQ-040 SHALL cover, with LUTRAM_READER_PERF_EN: 3 stalled cycles -> stall_cnt=3.
